// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment glyph reader: segment codes, FSM
// state type and the glyph decoder.
// Optional feature macro: SEG7_ALT_GLYPH_EN adds three alternate glyph shapes.
package seg7_pkg;

    // Segment bus bit0=a .. bit6=g, active-high
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;

    // Alternate shapes some display drivers emit
    localparam logic [6:0] GLYPH_ALT_7 = 7'h27; // seven with f segment
    localparam logic [6:0] GLYPH_ALT_9 = 7'h67; // nine without tail
    localparam logic [6:0] GLYPH_ALT_6 = 7'h3D; // flat six

    typedef enum logic [1:0] {
        StBlank,
        StSettle,
        StLocked,
        StBad
    } seg7_state_e;

    // Returns {legal, value}; value is 0 when the pattern is not a glyph
    function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'h00;
        case (seg)
            GLYPH_0:     res = {1'b1, 4'h0};
            GLYPH_1:     res = {1'b1, 4'h1};
            GLYPH_2:     res = {1'b1, 4'h2};
            GLYPH_3:     res = {1'b1, 4'h3};
            GLYPH_4:     res = {1'b1, 4'h4};
            GLYPH_5:     res = {1'b1, 4'h5};
            GLYPH_6:     res = {1'b1, 4'h6};
            GLYPH_7:     res = {1'b1, 4'h7};
            GLYPH_8:     res = {1'b1, 4'h8};
            GLYPH_9:     res = {1'b1, 4'h9};
            GLYPH_A:     res = {1'b1, 4'hA};
            GLYPH_B:     res = {1'b1, 4'hB};
            GLYPH_C:     res = {1'b1, 4'hC};
            GLYPH_D:     res = {1'b1, 4'hD};
            GLYPH_E:     res = {1'b1, 4'hE};
            GLYPH_F:     res = {1'b1, 4'hF};
`ifdef SEG7_ALT_GLYPH_EN
            GLYPH_ALT_7: res = {1'b1, 4'h7};
            GLYPH_ALT_9: res = {1'b1, 4'h9};
            GLYPH_ALT_6: res = {1'b1, 4'h6};
`endif
            default:     res = 5'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_glyph_reader_if.sv
// Segment-bus / result interface of the glyph reader. The master side drives
// the segment bus and clear; the slave side (the reader) returns results.
interface seg7_glyph_reader_if #(
    parameter int unsigned CNT_W = 8
);
    logic [6:0]       seg_in;
    logic             clr;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             glyph_err;
    logic             err_sticky;
    logic             locked;
    logic [15:0]      history;
    logic [CNT_W-1:0] count;

    modport master (
        output seg_in,
        output clr,
        input  digit,
        input  digit_valid,
        input  glyph_err,
        input  err_sticky,
        input  locked,
        input  history,
        input  count
    );

    modport slave (
        input  seg_in,
        input  clr,
        output digit,
        output digit_valid,
        output glyph_err,
        output err_sticky,
        output locked,
        output history,
        output count
    );
endinterface

// File: rtl/seg7_stable_filter.sv
// Synchronises the asynchronous segment bus and reports when the synchronised
// pattern has been identical for STABLE_CYCLES consecutive samples.
// STABLE_CYCLES is legal in 2..15 (4-bit stability counter).
module seg7_stable_filter #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [6:0] seg_s,
    output logic       stable,
    output logic       changed
);

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES - 1);

    logic [6:0] sync_q;
    logic [6:0] seg_s_q;
    logic [6:0] prev_q;
    logic [3:0] stab_q;

    // Two-flop synchroniser, then a one-cycle-delayed copy for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            seg_s_q <= '0;
            prev_q  <= '0;
        end else begin
            sync_q  <= seg_in;
            seg_s_q <= sync_q;
            prev_q  <= seg_s_q;
        end
    end

    assign changed = (seg_s_q != prev_q);

    // Stability counter: restarts on any change, saturates at STAB_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q <= '0;
        end else if (changed) begin
            stab_q <= '0;
        end else if (stab_q != STAB_MAX) begin
            stab_q <= stab_q + 4'd1;
        end
    end

    // A change in the current sample always overrides a saturated counter
    assign stable = !changed && (stab_q == STAB_MAX);
    assign seg_s  = seg_s_q;

endmodule

// File: rtl/seg7_glyph_reader.sv
// Seven-segment glyph reader: waits for a stable segment pattern, decodes it
// back to a hex digit (or flags it as not a glyph), and keeps a four-digit
// history plus a saturating count of accepted digits.
// Optional feature macro: SEG7_ALT_GLYPH_EN (alternate glyphs, in seg7_pkg).
module seg7_glyph_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_glyph_reader_if.slave  bus
);

    logic [6:0]       seg_s;
    logic             stable;
    logic             changed;
    logic [4:0]       dec;
    logic             dec_legal;
    logic [3:0]       dec_value;

    seg7_state_e      state_q;
    logic [3:0]       digit_q;
    logic             digit_valid_q;
    logic             glyph_err_q;
    logic             err_sticky_q;
    logic [15:0]      history_q;
    logic [CNT_W-1:0] count_q;

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_in  (bus.seg_in),
        .seg_s   (seg_s),
        .stable  (stable),
        .changed (changed)
    );

    assign dec       = seg7_decode(seg_s);
    assign dec_legal = dec[4];
    assign dec_value = dec[3:0];

    // FSM with registered result outputs; clr is applied last so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBlank;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            glyph_err_q   <= 1'b0;
            err_sticky_q  <= 1'b0;
            history_q     <= '0;
            count_q       <= '0;
        end else begin
            digit_valid_q <= 1'b0;
            glyph_err_q   <= 1'b0;
            unique case (state_q)
                StBlank: begin
                    if (seg_s != GLYPH_BLANK) begin
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (stable) begin
                        if (seg_s == GLYPH_BLANK) begin
                            state_q <= StBlank;
                        end else if (dec_legal) begin
                            state_q       <= StLocked;
                            digit_valid_q <= 1'b1;
                            digit_q       <= dec_value;
                            history_q     <= {history_q[11:0], dec_value};
                            if (count_q != '1) begin
                                count_q <= count_q + 1'b1;
                            end
                        end else begin
                            state_q      <= StBad;
                            glyph_err_q  <= 1'b1;
                            err_sticky_q <= 1'b1;
                        end
                    end
                end
                StLocked, StBad: begin
                    if (changed) begin
                        state_q <= (seg_s == GLYPH_BLANK) ? StBlank : StSettle;
                    end
                end
                default: state_q <= StBlank;
            endcase
            if (bus.clr) begin
                history_q    <= '0;
                count_q      <= '0;
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.glyph_err   = glyph_err_q;
    assign bus.err_sticky  = err_sticky_q;
    assign bus.locked      = (state_q == StLocked);
    assign bus.history     = history_q;
    assign bus.count       = count_q;

endmodule
